// File: rtl/llc_input_arbiter_if.sv
// Handshake bundle between the LLC input channels, the arbiter and the decode stage.
// The slave modport is the arbiter; the master modport is the channel/decode side.
interface llc_input_arbiter_if;
  logic [3:0]       chan_valid;
  logic [3:0]       chan_block;
  logic             decode_en;
  logic             grant_ack;
  logic             grant_valid;
  logic [3:0]       grant;
  logic [3:0]       pop;
  logic             promoted;
  logic             idle;
  logic [3:0][15:0] stat_grants;
  logic [15:0]      stat_promos;

  modport master (
    output chan_valid, chan_block, decode_en, grant_ack,
    input  grant_valid, grant, pop, promoted, idle, stat_grants, stat_promos
  );

  modport slave (
    input  chan_valid, chan_block, decode_en, grant_ack,
    output grant_valid, grant, pop, promoted, idle, stat_grants, stat_promos
  );
endinterface

// File: rtl/llc_input_arbiter.sv
// LLC input arbiter: fixed priority rst>rsp>req>dma with req/dma aging; grant 1 cycle after decode_en,
// held until grant_ack (back-to-back when ack and decode_en coincide). Counters built with LLC_ARB_STATS_EN.
module llc_input_arbiter #(
  parameter int STARVE_LIMIT = 15,
  parameter int AGE_W        = 4
) (
  input  logic               clk,
  input  logic               rst,
  llc_input_arbiter_if.slave bus
);

  localparam logic [AGE_W-1:0] LIMIT = AGE_W'(STARVE_LIMIT);

  typedef enum logic {ARB, HOLD} state_t;

  state_t           state_q, state_d;
  logic             grant_vld_q, grant_vld_d;
  logic [3:0]       grant_q, grant_d;
  logic             promo_q, promo_d;
  logic             idle_q, idle_d;
  logic [AGE_W-1:0] age_req_q, age_req_d;
  logic [AGE_W-1:0] age_dma_q, age_dma_d;

  logic [3:0] elig;
  logic [3:0] win;
  logic       win_promo;
  logic       arb_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB;
      grant_vld_q <= 1'b0;
      grant_q     <= '0;
      promo_q     <= 1'b0;
      idle_q      <= 1'b0;
      age_req_q   <= '0;
      age_dma_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_vld_q <= grant_vld_d;
      grant_q     <= grant_d;
      promo_q     <= promo_d;
      idle_q      <= idle_d;
      age_req_q   <= age_req_d;
      age_dma_q   <= age_dma_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_vld_d = grant_vld_q;
    grant_d     = grant_q;
    promo_d     = promo_q;
    idle_d      = idle_q;
    age_req_d   = age_req_q;
    age_dma_d   = age_dma_q;
    win         = '0;
    win_promo   = 1'b0;

    // The outstanding grantee pops this cycle, so it must not win a back-to-back slot.
    elig = bus.chan_valid & ~bus.chan_block & ((state_q == HOLD) ? ~grant_q : 4'b1111);

    if (elig[0]) begin
      win = 4'b0001;
    end else if (elig[2] && age_req_q == LIMIT) begin
      win       = 4'b0100;
      win_promo = 1'b1;
    end else if (elig[3] && age_dma_q == LIMIT) begin
      win       = 4'b1000;
      win_promo = 1'b1;
    end else if (elig[1]) begin
      win = 4'b0010;
    end else if (elig[2]) begin
      win = 4'b0100;
    end else if (elig[3]) begin
      win = 4'b1000;
    end

    arb_fire = bus.decode_en && (state_q == ARB || bus.grant_ack);

    case (state_q)
      ARB: begin
        if (bus.decode_en) begin
          if (|win) begin
            grant_d     = win;
            promo_d     = win_promo;
            grant_vld_d = 1'b1;
            idle_d      = 1'b0;
            state_d     = HOLD;
          end else begin
            idle_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.grant_ack) begin
          if (bus.decode_en && |win) begin
            grant_d = win;
            promo_d = win_promo;
            idle_d  = 1'b0;
          end else begin
            grant_d     = '0;
            promo_d     = 1'b0;
            grant_vld_d = 1'b0;
            state_d     = ARB;
            if (bus.decode_en) idle_d = 1'b1;
          end
        end
      end
      default: state_d = ARB;
    endcase

    if (arb_fire) begin
      if (win[2] || !elig[2])         age_req_d = '0;
      else if (age_req_q != LIMIT)    age_req_d = age_req_q + AGE_W'(1);
      if (win[3] || !elig[3])         age_dma_d = '0;
      else if (age_dma_q != LIMIT)    age_dma_d = age_dma_q + AGE_W'(1);
    end
  end

  assign bus.grant_valid = grant_vld_q;
  assign bus.grant       = grant_q;
  assign bus.promoted    = promo_q;
  assign bus.idle        = idle_q;
  assign bus.pop         = grant_q & {4{bus.grant_ack & grant_vld_q}};

`ifdef LLC_ARB_STATS_EN
  logic [3:0][15:0] stat_grants_q;
  logic [15:0]      stat_promos_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_grants_q <= '0;
      stat_promos_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (bus.pop[i]) stat_grants_q[i] <= stat_grants_q[i] + 16'd1;
      end
      if (arb_fire && win_promo) stat_promos_q <= stat_promos_q + 16'd1;
    end
  end

  assign bus.stat_grants = stat_grants_q;
  assign bus.stat_promos = stat_promos_q;
`else
  assign bus.stat_grants = '0;
  assign bus.stat_promos = '0;
`endif

endmodule
